imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 77 +++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program image into instruction memory, then releases the CPU at BASE_ADDR
// Ports: clk/rst_n (async active-low); start begins a load from IDLE, DONE or ERROR;
// s_valid/s_data/s_last/s_ready form the instruction stream; mem_we/mem_addr/mem_wdata write
// instruction memory one cycle after each accepted word; busy/done/err_overflow report state;
// cpu_run/pc_out release the CPU; word_count/checksum summarise the current or last load.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd128,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err_overflow,
    output logic        cpu_run,
    output logic [31:0] pc_out,
    output logic [6:0]  word_count,
    output logic [31:0] checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
    localparam logic [6:0] max_w = 7'(MAX_WORDS);
    state_t state, state_nx;
    logic [31:0] ptr;
    logic xfer;
    assign s_ready = state == LOAD;
    assign xfer = s_valid && s_ready;
    assign busy = state == LOAD;
    assign done = state == DONE;
    assign err_overflow = state == ERROR;
    assign cpu_run = done;
    assign pc_out = done ? BASE_ADDR : 32'd0;
    // A last-marked word always wins, so an image of exactly MAX_WORDS completes normally.
    always_comb begin
        state_nx = state;
        if (state == LOAD) begin
            if (xfer && s_last) state_nx = DONE;
            else if (xfer && word_count + 7'd1 == max_w) state_nx = ERROR;
        end else if (start) begin
            state_nx = LOAD;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            ptr        <= 32'd0;
            word_count <= 7'd0;
            checksum   <= 32'd0;
        end else begin
            mem_we <= xfer;
            if (xfer) begin
                mem_addr   <= ptr;
                mem_wdata  <= s_data;
                ptr        <= ptr + 32'd4;
                word_count <= word_count + 7'd1;
                checksum   <= checksum ^ s_data;
            end else if (start && state != LOAD) begin
                ptr        <= BASE_ADDR;
                word_count <= 7'd0;
                checksum   <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (MAX_WORDS=4)
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, mem_we, busy, done, err_overflow, cpu_run;
    logic [31:0] mem_addr, mem_wdata, pc_out, checksum;
    logic [6:0]  word_count;
    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [31:0] w [3];
    logic [31:0] v [5];

    imem_loader #(.BASE_ADDR(32'd128), .MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err_overflow(err_overflow),
        .cpu_run(cpu_run), .pc_out(pc_out), .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) wr_cnt++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic vld, input logic [31:0] d, input logic l);
        s_valid = vld;
        s_data = d;
        s_last = l;
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " flags"}, {28'd0, busy, done, err_overflow, cpu_run}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " pc_out"}, pc_out, 32'd0);
        chk({tag, " word_count"}, {25'd0, word_count}, 32'd0);
        chk({tag, " checksum"}, checksum, 32'd0);
    endtask

    initial begin
        w[0] = 32'h20080005; w[1] = 32'h20090007; w[2] = 32'h01095020;
        v[0] = 32'h11111111; v[1] = 32'h22220000; v[2] = 32'h00003333;
        v[3] = 32'h40000004; v[4] = 32'h55555555;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
        #1;
        chk_idle_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        chk("idle s_ready", {31'd0, s_ready}, 32'd0);

        // back-to-back 3-word image
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load busy", {31'd0, busy}, 32'd1);
        chk("load s_ready", {31'd0, s_ready}, 32'd1);
        chk("load no write", {31'd0, mem_we}, 32'd0);
        wr_base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, w[i], i == 2);
            chk("b2b we", {31'd0, mem_we}, 32'd1);
            chk("b2b addr", mem_addr, 32'd128 + 32'(4 * i));
            chk("b2b wdata", mem_wdata, w[i]);
        end
        s_valid = 1'b0;
        chk("b2b done", {28'd0, busy, done, err_overflow, cpu_run}, 32'b0101);
        chk("b2b pc_out", pc_out, 32'd128);
        chk("b2b word_count", {25'd0, word_count}, 32'd3);
        chk("b2b checksum", checksum, 32'h01085022);
        step();
        chk("b2b writes", 32'(wr_cnt - wr_base), 32'd3);
        chk("done s_ready", {31'd0, s_ready}, 32'd0);
        chk("done hold", {25'd0, word_count}, 32'd3);

        // same image with 2 idle cycles between words; start from DONE reloads
        start = 1'b1;
        step();
        start = 1'b0;
        chk("reload cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("reload busy", {31'd0, busy}, 32'd1);
        chk("reload cleared", {25'd0, word_count} | checksum, 32'd0);
        wr_base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, w[i], i == 2);
            chk("gap we", {31'd0, mem_we}, 32'd1);
            chk("gap addr", mem_addr, 32'd128 + 32'(4 * i));
            s_valid = 1'b0;
            s_data = 32'hdeadbeef;
            s_last = 1'b1;
            if (i < 2) begin
                step();
                chk("gap idle1", {31'd0, mem_we}, 32'd0);
                step();
                chk("gap idle2", {31'd0, mem_we}, 32'd0);
            end
        end
        step();
        chk("gap writes", 32'(wr_cnt - wr_base), 32'd3);
        chk("gap done", {31'd0, done}, 32'd1);
        chk("gap checksum", checksum, 32'h01085022);

        // start during LOAD is ignored; start in DONE reloads with a fresh checksum
        start = 1'b1;
        step();
        start = 1'b1;
        put(1'b1, w[0], 1'b0);
        start = 1'b0;
        chk("ign addr", mem_addr, 32'd128);
        chk("ign count", {25'd0, word_count}, 32'd1);
        start = 1'b1;
        put(1'b0, 32'd0, 1'b0);
        start = 1'b0;
        chk("ign busy", {31'd0, busy}, 32'd1);
        chk("ign count2", {25'd0, word_count}, 32'd1);
        put(1'b1, w[1], 1'b0);
        chk("ign addr2", mem_addr, 32'd132);
        put(1'b1, w[2], 1'b1);
        s_valid = 1'b0;
        chk("ign done", {31'd0, cpu_run}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart cpu_run", {31'd0, cpu_run}, 32'd0);

        // single-word image
        put(1'b1, 32'h08000020, 1'b1);
        s_valid = 1'b0;
        chk("one addr", mem_addr, 32'd128);
        chk("one wdata", mem_wdata, 32'h08000020);
        chk("one done", {31'd0, done}, 32'd1);
        chk("one count", {25'd0, word_count}, 32'd1);
        chk("one checksum", checksum, 32'h08000020);

        // overflow: 5 words, s_last only on word 5
        start = 1'b1;
        step();
        start = 1'b0;
        wr_base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, v[i], 1'b0);
            chk("ovf addr", mem_addr, 32'd128 + 32'(4 * i));
        end
        chk("ovf err", {28'd0, busy, done, err_overflow, cpu_run}, 32'b0010);
        chk("ovf s_ready", {31'd0, s_ready}, 32'd0);
        chk("ovf count", {25'd0, word_count}, 32'd4);
        chk("ovf pc_out", pc_out, 32'd0);
        put(1'b1, v[4], 1'b1);
        chk("ovf w5 rejected", {31'd0, mem_we}, 32'd0);
        chk("ovf count hold", {25'd0, word_count}, 32'd4);
        chk("ovf checksum", checksum, v[0] ^ v[1] ^ v[2] ^ v[3]);
        chk("ovf writes", 32'(wr_cnt - wr_base), 32'd4);
        s_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovf restart busy", {31'd0, busy}, 32'd1);
        chk("ovf restart count", {25'd0, word_count}, 32'd0);

        // exactly MAX_WORDS with s_last on the last word completes normally
        for (int i = 0; i < 4; i++) put(1'b1, v[i], i == 3);
        s_valid = 1'b0;
        chk("full done", {28'd0, busy, done, err_overflow, cpu_run}, 32'b0101);
        chk("full count", {25'd0, word_count}, 32'd4);

        // asynchronous reset mid-load after 2 of 3 words
        start = 1'b1;
        step();
        start = 1'b0;
        put(1'b1, w[0], 1'b0);
        put(1'b1, w[1], 1'b0);
        chk("rst pre addr", mem_addr, 32'd132);
        s_data = w[2];
        s_last = 1'b1;
        wr_base = wr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("async rst");
        step();
        chk("rst no write", 32'(wr_cnt - wr_base), 32'd0);
        chk("rst held we", {31'd0, mem_we}, 32'd0);
        rst_n = 1'b1;
        s_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        put(1'b1, w[0], 1'b1);
        s_valid = 1'b0;
        chk("post rst addr", mem_addr, 32'd128);
        chk("post rst count", {25'd0, word_count}, 32'd1);
        chk("post rst done", {31'd0, done}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
